// File: rtl/am_agc_ctrl.sv
// Peak-tracking AGC for the AM demodulator audio gain; pushes {carrier, gain} to demod reg 0 over Wishbone.
// Define AGC_CARRIER_EN to derive the carrier word from the window mean instead of i_carrier.
//
// state    | meaning
// MEASURE  | accumulate peak magnitude over 2^LGWINDOW strobed samples
// DECIDE   | one cycle: compute new gain/carrier, decide whether a write is needed
// BUS_REQ  | cyc/stb/we asserted, waiting for the slave to drop stall
// BUS_WAIT | request accepted, cyc held until ack
module am_agc_ctrl #(
    parameter int          LGWINDOW     = 10,
    parameter logic [15:0] INITIAL_GAIN = 16'h0100,
    parameter logic [15:0] MIN_GAIN     = 16'h0010,
    parameter logic [15:0] MAX_GAIN     = 16'hff00,
    parameter int          STEP_SHIFT   = 4,
    parameter int          HYST         = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_agc_en,
    input  logic        i_sample_ce,
    input  logic [7:0]  i_sample,
    input  logic [7:0]  i_target,
    input  logic [15:0] i_carrier,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [1:0]  o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_stall,
    input  logic        i_wb_ack,
    output logic [15:0] o_gain,
    output logic        o_update
);

    typedef enum logic [1:0] {
        MEASURE  = 2'd0,
        DECIDE   = 2'd1,
        BUS_REQ  = 2'd2,
        BUS_WAIT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [LGWINDOW-1:0] cnt_q, cnt_d;
    logic [7:0]          peak_q, peak_d;
    logic [15:0]         gain_q, gain_d;
    logic [31:0]         pend_q, pend_d;
    logic [31:0]         last_q, last_d;
    logic                cyc_q, cyc_d;
    logic                stb_q, stb_d;
    logic                update_q, update_d;
    logic                commit;

    logic [7:0]  mag;
    logic [8:0]  peak_ext, hi_thr, lo_thr;
    logic [15:0] step, gain_dn_raw, gain_dn, gain_up, gain_new;
    logic [16:0] gain_up_raw;
    logic [15:0] carrier_new, carrier_rst;
    logic [31:0] word_new;

    // -128 maps to 128, which still fits the unsigned 8-bit magnitude
    assign mag      = i_sample[7] ? (~i_sample + 8'd1) : i_sample;
    assign peak_ext = {1'b0, peak_q};
    assign hi_thr   = {1'b0, i_target} + 9'(HYST);
    assign lo_thr   = ({1'b0, i_target} >= 9'(HYST)) ? ({1'b0, i_target} - 9'(HYST)) : 9'd0;

    assign step        = gain_q >> STEP_SHIFT;
    assign gain_dn_raw = gain_q - step;
    assign gain_dn     = (gain_dn_raw < MIN_GAIN) ? MIN_GAIN : gain_dn_raw;
    assign gain_up_raw = {1'b0, gain_q} + {1'b0, step} + 17'd1;
    assign gain_up     = (gain_up_raw > {1'b0, MAX_GAIN}) ? MAX_GAIN : gain_up_raw[15:0];

    always_comb begin
        gain_new = gain_q;
        if (peak_ext > hi_thr) begin
            gain_new = gain_dn;
        end else if (peak_ext < lo_thr) begin
            gain_new = gain_up;
        end
    end

`ifdef AGC_CARRIER_EN
    localparam int SUM_W = 8 + LGWINDOW;
    logic signed [SUM_W-1:0] sum_q, sum_d;
    logic signed [7:0]       mean;
    logic signed [24:0]      prod;

    assign mean        = 8'(sum_q >>> LGWINDOW);
    assign prod        = 25'(mean) * 25'($signed({1'b0, gain_new}));
    assign carrier_new = 16'(prod >>> 8);
    assign carrier_rst = 16'h0000;
`else
    assign carrier_new = i_carrier;
    assign carrier_rst = i_carrier;
`endif

    assign word_new = {carrier_new, gain_new};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        peak_d   = peak_q;
        gain_d   = gain_q;
        pend_d   = pend_q;
        last_d   = last_q;
        cyc_d    = cyc_q;
        stb_d    = stb_q;
        update_d = 1'b0;
        commit   = 1'b0;
`ifdef AGC_CARRIER_EN
        sum_d    = sum_q;
`endif
        case (state_q)
            MEASURE: begin
                if (!i_agc_en) begin
                    cnt_d  = '0;
                    peak_d = '0;
`ifdef AGC_CARRIER_EN
                    sum_d  = '0;
`endif
                end else if (i_sample_ce) begin
                    cnt_d = cnt_q + LGWINDOW'(1);
                    if (mag > peak_q) begin
                        peak_d = mag;
                    end
`ifdef AGC_CARRIER_EN
                    sum_d = sum_q + SUM_W'($signed(i_sample));
`endif
                    if (cnt_q == '1) begin
                        state_d = DECIDE;
                    end
                end
            end
            DECIDE: begin
                cnt_d  = '0;
                peak_d = '0;
`ifdef AGC_CARRIER_EN
                sum_d  = '0;
`endif
                pend_d = word_new;
                if (word_new != last_q) begin
                    state_d = BUS_REQ;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                end else begin
                    state_d = MEASURE;
                end
            end
            BUS_REQ: begin
                // after reset the request is raised here rather than in DECIDE
                if (!stb_q) begin
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                end else if (!i_wb_stall) begin
                    stb_d = 1'b0;
                    if (i_wb_ack) begin
                        commit = 1'b1;
                    end else begin
                        state_d = BUS_WAIT;
                    end
                end
            end
            BUS_WAIT: begin
                if (i_wb_ack) begin
                    commit = 1'b1;
                end
            end
            default: state_d = MEASURE;
        endcase

        if (commit) begin
            cyc_d    = 1'b0;
            gain_d   = pend_q[15:0];
            last_d   = pend_q;
            update_d = 1'b1;
            state_d  = MEASURE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= BUS_REQ;
            cnt_q    <= '0;
            peak_q   <= '0;
            gain_q   <= INITIAL_GAIN;
            pend_q   <= {carrier_rst, INITIAL_GAIN};
            last_q   <= '0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            update_q <= 1'b0;
`ifdef AGC_CARRIER_EN
            sum_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            peak_q   <= peak_d;
            gain_q   <= gain_d;
            pend_q   <= pend_d;
            last_q   <= last_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            update_q <= update_d;
`ifdef AGC_CARRIER_EN
            sum_q    <= sum_d;
`endif
        end
    end

    assign o_wb_cyc  = cyc_q;
    assign o_wb_stb  = stb_q;
    assign o_wb_we   = cyc_q;
    assign o_wb_addr = 2'b00;
    assign o_wb_data = pend_q;
    assign o_wb_sel  = 4'hf;
    assign o_gain    = gain_q;
    assign o_update  = update_q;

endmodule

// File: tb/tb_am_agc_ctrl.sv
// Directed bench for am_agc_ctrl with a 16-sample window; slave responses are scripted per scenario.
module tb_am_agc_ctrl;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_agc_en = 1'b1;
    logic        i_sample_ce = 1'b0;
    logic [7:0]  i_sample = 8'h00;
    logic [7:0]  i_target = 8'd64;
    logic [15:0] i_carrier = 16'h0080;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [1:0]  o_wb_addr;
    logic [31:0] o_wb_data;
    logic [3:0]  o_wb_sel;
    logic        i_wb_stall = 1'b0;
    logic        i_wb_ack = 1'b0;
    logic [15:0] o_gain;
    logic        o_update;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    am_agc_ctrl #(.LGWINDOW(4)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_agc_en(i_agc_en),
        .i_sample_ce(i_sample_ce), .i_sample(i_sample), .i_target(i_target),
        .i_carrier(i_carrier), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
        .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
        .o_wb_sel(o_wb_sel), .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack),
        .o_gain(o_gain), .o_update(o_update)
    );

    task automatic send_window(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            i_sample    = v;
            i_sample_ce = 1'b1;
            @(negedge clk);
        end
        i_sample_ce = 1'b0;
    endtask

    task automatic wait_stb(output int lat);
        lat = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (o_wb_stb) begin
                lat = i;
                break;
            end
        end
    endtask

    // one write acked the cycle after stb is accepted; returns what was observed
    task automatic run_write(output int lat, output logic [31:0] data, output logic [15:0] g,
                             output logic upd, output logic proto);
        wait_stb(lat);
        data  = o_wb_data;
        proto = o_wb_cyc && o_wb_we && (o_wb_sel == 4'hf) && (o_wb_addr == 2'b00);
        g     = 16'h0000;
        upd   = 1'b0;
        if (lat < 0) begin
            proto = 1'b0;
            return;
        end
        @(negedge clk);
        proto    = proto && !o_wb_stb && o_wb_cyc;
        i_wb_ack = 1'b1;
        @(negedge clk);
        i_wb_ack = 1'b0;
        proto    = proto && !o_wb_cyc;
        upd      = o_update;
        g        = o_gain;
        @(negedge clk);
        proto = proto && !o_update;
    endtask

    task automatic quiet(input int n, output logic saw);
        saw = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (o_wb_cyc) saw = 1'b1;
        end
    endtask

    task automatic test_reset(input logic [31:0] exp_data);
        int lat; logic [31:0] d; logic [15:0] g; logic u, p;
        i_reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if ({o_wb_cyc, o_wb_stb, o_wb_we} !== 3'b000) begin miscompares++; $display("FAIL reset_bus: got %b expected 000", {o_wb_cyc, o_wb_stb, o_wb_we}); end
        vectors++; if (o_update !== 1'b0) begin miscompares++; $display("FAIL reset_update: got %b expected 0", o_update); end
        vectors++; if (o_gain !== 16'h0100) begin miscompares++; $display("FAIL reset_gain: got %h expected 0100", o_gain); end
        i_reset = 1'b0;
        run_write(lat, d, g, u, p);
        vectors++; if (lat !== 0) begin miscompares++; $display("FAIL reset_write_latency: got %0d expected 0", lat); end
        vectors++; if (d !== exp_data) begin miscompares++; $display("FAIL reset_write_data: got %h expected %h", d, exp_data); end
        vectors++; if (u !== 1'b1) begin miscompares++; $display("FAIL reset_update_pulse: got %b expected 1", u); end
        vectors++; if (g !== 16'h0100) begin miscompares++; $display("FAIL reset_gain_after: got %h expected 0100", g); end
        vectors++; if (p !== 1'b1) begin miscompares++; $display("FAIL reset_protocol: got %b expected 1", p); end
    endtask

    task automatic test_hold_band();
        logic saw;
        send_window(8'd72, 8);
        send_window(8'hB8, 8);
        quiet(10, saw);
        vectors++; if (saw !== 1'b0) begin miscompares++; $display("FAIL hold_hi_edge: got cyc %b expected 0", saw); end
        send_window(8'd56, 16);
        quiet(10, saw);
        vectors++; if (saw !== 1'b0) begin miscompares++; $display("FAIL hold_lo_edge: got cyc %b expected 0", saw); end
        vectors++; if (o_gain !== 16'h0100) begin miscompares++; $display("FAIL hold_gain: got %h expected 0100", o_gain); end
    endtask

    task automatic test_window_write(input string name, input logic [7:0] v, input logic [31:0] exp_data);
        int lat; logic [31:0] d; logic [15:0] g; logic u, p;
        send_window(v, 16);
        run_write(lat, d, g, u, p);
        vectors++; if (lat !== 0) begin miscompares++; $display("FAIL %s_latency: got %0d expected 0", name, lat); end
        vectors++; if (d !== exp_data) begin miscompares++; $display("FAIL %s_data: got %h expected %h", name, d, exp_data); end
        vectors++; if (g !== exp_data[15:0]) begin miscompares++; $display("FAIL %s_gain: got %h expected %h", name, g, exp_data[15:0]); end
        vectors++; if ({u, p} !== 2'b11) begin miscompares++; $display("FAIL %s_update_protocol: got %b expected 11", name, {u, p}); end
    endtask

    task automatic test_stall_window();
        int lat; logic [31:0] d; logic [15:0] g; logic u, p, bad, saw;
        i_wb_stall = 1'b1;
        send_window(8'h00, 16);
        wait_stb(lat);
        vectors++; if (lat !== 0) begin miscompares++; $display("FAIL stall_latency: got %0d expected 0", lat); end
        vectors++; if (o_wb_data !== 32'h0080_00F0) begin miscompares++; $display("FAIL stall_data: got %h expected 008000f0", o_wb_data); end
        i_sample    = 8'h7f;
        i_sample_ce = 1'b1;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (!(o_wb_stb && o_wb_cyc)) bad = 1'b1;
        end
        vectors++; if (bad !== 1'b0) begin miscompares++; $display("FAIL stall_stb_held: got drop %b expected 0", bad); end
        i_wb_stall = 1'b0;
        @(negedge clk);
        vectors++; if ({o_wb_stb, o_wb_cyc} !== 2'b01) begin miscompares++; $display("FAIL stall_release: got stb/cyc %b expected 01", {o_wb_stb, o_wb_cyc}); end
        bad = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (!o_wb_cyc || o_wb_stb) bad = 1'b1;
        end
        vectors++; if (bad !== 1'b0) begin miscompares++; $display("FAIL stall_cyc_until_ack: got drop %b expected 0", bad); end
        i_wb_ack = 1'b1;
        @(negedge clk);
        i_wb_ack    = 1'b0;
        i_sample_ce = 1'b0;
        vectors++; if ({o_wb_cyc, o_update} !== 2'b01) begin miscompares++; $display("FAIL stall_ack: got cyc/update %b expected 01", {o_wb_cyc, o_update}); end
        vectors++; if (o_gain !== 16'h00F0) begin miscompares++; $display("FAIL stall_gain: got %h expected 00f0", o_gain); end
        send_window(8'h64, 15);
        quiet(6, saw);
        vectors++; if (saw !== 1'b0) begin miscompares++; $display("FAIL fresh_window_early: got cyc %b expected 0", saw); end
        send_window(8'h64, 1);
        run_write(lat, d, g, u, p);
        vectors++; if (lat !== 0) begin miscompares++; $display("FAIL fresh_window_latency: got %0d expected 0", lat); end
        vectors++; if (d !== 32'h0080_00E1) begin miscompares++; $display("FAIL fresh_window_data: got %h expected 008000e1", d); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] d; logic [15:0] g; logic u, p;
        i_carrier = 16'h0080;
        send_window(8'h64, 16);
        wait_stb(lat);
        vectors++; if (o_wb_data !== 32'h0080_00D3) begin miscompares++; $display("FAIL midreset_pre_data: got %h expected 008000d3", o_wb_data); end
        @(negedge clk);
        vectors++; if ({o_wb_stb, o_wb_cyc} !== 2'b01) begin miscompares++; $display("FAIL midreset_wait: got stb/cyc %b expected 01", {o_wb_stb, o_wb_cyc}); end
        i_reset = 1'b1;
        @(negedge clk);
        vectors++; if ({o_wb_cyc, o_wb_stb} !== 2'b00) begin miscompares++; $display("FAIL midreset_drop: got cyc/stb %b expected 00", {o_wb_cyc, o_wb_stb}); end
        vectors++; if (o_gain !== 16'h0100) begin miscompares++; $display("FAIL midreset_gain: got %h expected 0100", o_gain); end
        i_reset = 1'b0;
        run_write(lat, d, g, u, p);
        vectors++; if (lat !== 0) begin miscompares++; $display("FAIL midreset_reissue_latency: got %0d expected 0", lat); end
        vectors++; if (d !== 32'h0080_0100) begin miscompares++; $display("FAIL midreset_reissue_data: got %h expected 00800100", d); end
        vectors++; if ({u, p} !== 2'b11) begin miscompares++; $display("FAIL midreset_reissue_protocol: got %b expected 11", {u, p}); end
    endtask

    task automatic test_clamp_max();
        int lat; logic [31:0] d; logic [15:0] g; logic u, p, saw;
        logic [15:0] g_model, nxt;
        logic [16:0] sum17;
        g_model = 16'h0100;
        for (int w = 0; w < 150; w++) begin
            if (g_model == 16'hff00) break;
            sum17 = {1'b0, g_model} + {1'b0, g_model >> 4} + 17'd1;
            nxt   = (sum17 > 17'h0ff00) ? 16'hff00 : sum17[15:0];
            send_window(8'h00, 16);
            run_write(lat, d, g, u, p);
            vectors++; if (d !== {16'h0080, nxt}) begin miscompares++; $display("FAIL clamp_step_data: got %h expected %h", d, {16'h0080, nxt}); end
            vectors++; if (g !== nxt) begin miscompares++; $display("FAIL clamp_step_gain: got %h expected %h", g, nxt); end
            g_model = nxt;
        end
        vectors++; if (o_gain !== 16'hff00) begin miscompares++; $display("FAIL clamp_max_gain: got %h expected ff00", o_gain); end
        send_window(8'h00, 16);
        quiet(10, saw);
        vectors++; if (saw !== 1'b0) begin miscompares++; $display("FAIL clamp_no_rewrite: got cyc %b expected 0", saw); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef AGC_CARRIER_EN
        test_reset(32'h0000_0100);
        i_target = 8'd32;
        test_window_write("carrier_auto", 8'h20, 32'h0020_0100);
`else
        test_reset(32'h0080_0100);
        test_hold_band();
        test_window_write("decrease", 8'h64, 32'h0080_00F0);
        test_window_write("neg_full_scale", 8'h80, 32'h0080_00E1);
        test_stall_window();
        i_carrier = 16'h1234;
        test_window_write("carrier_change", 8'h40, 32'h1234_00E1);
        test_reset_mid();
        test_clamp_max();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
